harris_corner_logger: RTL and testbench
=======================================

Name: harris_corner_logger

Overview:
- Collects corner detections from the Harris score stage into a buffered stream of (x, y, score) events.
- Tracks raster position of each window result and counts corners per frame.
- Exposes events through a valid/ready FIFO so a host, DMA engine or bench monitor can drain them without stalling the pipeline.
- Replaces the print-only corner monitor with synthesizable logic that has frame framing, backpressure and overflow accounting.

Parameters:
- IMG_W, 640, window results per line; x wraps after IMG_W-1.
- IMG_H, 480, lines per frame; y wraps after IMG_H-1.
- XW, $clog2(IMG_W), x coordinate width.
- YW, $clog2(IMG_H), y coordinate width.
- SCORE_W, 64, signed Harris score width.
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 32, corner counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  one window result this cycle.
- sof  in  1  qualifies the current in_valid result as pixel (0,0).
- is_corner  in  1  corner decision for the current result.
- score  in  SCORE_W  signed Harris R for the current result.
- out_valid  out  1  FIFO head holds an event.
- out_ready  in  1  consumer accepts the head.
- out_x  out  XW  event x.
- out_y  out  YW  event y.
- out_score  out  SCORE_W  event score.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- corner_count  out  CNT_W  corners in the last completed frame, including dropped corners.
- drop_count  out  16  saturating count of events lost to a full FIFO; cleared only by reset.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: FSM goes to IDLE; x, y, FIFO pointers, counters, frame_done and out_valid all go to 0. out_x, out_y and out_score read 0.
- FSM states:
  - IDLE: in_valid without sof is ignored. in_valid&sof processes the result as (0,0) and moves to RUN.
  - RUN: every in_valid advances x; at x=IMG_W-1, x wraps to 0 and y increments.
  - Last pixel: in_valid at (IMG_W-1, IMG_H-1) returns the FSM to IDLE. Next cycle: frame_done=1 and corner_count latches the running count, including the last pixel.
  - sof during RUN: aborts the frame and restarts at (0,0). No frame_done; corner_count holds its old value. The running count restarts from this pixel's is_corner.
- Accepted result (IDLE with sof, or RUN): if is_corner, increment the running count and request a push of {x, y, score}.
- Push/pop rules:
  - Pop occurs when out_valid&out_ready.
  - Push while full succeeds only if a pop occurs in the same cycle; otherwise the event is dropped and drop_count increments, saturating at 16'hFFFF.
  - Simultaneous push and pop with the FIFO non-full leaves the level unchanged.
- Timing: FIFO is first-word-fall-through. An event pushed in cycle N is visible on out_* in cycle N+1 when the FIFO was empty. out_* stay stable while out_valid&!out_ready.
- Pointers wrap modulo DEPTH; an extra MSB distinguishes full from empty.
- Running count saturates at 2^CNT_W-1.
- reset asserted mid-frame or mid-drain: all state clears immediately, with no output glitch requirement beyond the reset values.

Optional Feature:
- Macro CORNER_LOG_SCORE_EN.
- Defined: the score field is stored per entry and drives out_score.
- Undefined: score is not stored, FIFO entries are XW+YW bits, and out_score is tied to 0. All other behaviour is identical.

Decomposition:
- Package harris_pkg holds IMG_W/IMG_H defaults, the SCORE_W default, and typedef corner_evt_t {x, y, score}. Under CORNER_LOG_SCORE_EN, corner_evt_t includes score.
- One sub-module: corner_evt_fifo, a parametrised FWFT sync FIFO (DEPTH, entry width) with level and full/empty.
- FSM, position counters and frame counters live in the top module.

Test Plan:
All scenarios use IMG_W=4, IMG_H=2, DEPTH=4.
1. Reset, then out_ready=1; frame with sof at the first pixel and corners at indices 1 and 6 -> events (1,0) then (2,1); frame_done pulses once, one cycle after index 7; corner_count=2.
2. in_valid with sof=0 and is_corner=1 while IDLE -> no event, counters unchanged.
3. out_ready=0; 6 corners in one frame -> fifo_level=4, drop_count=2, corner_count=6; then out_ready=1 -> first four events drained in order, out_valid falls.
4. FIFO full, push and pop in the same cycle -> no drop, level stays 4, new event at tail.
5. sof at index 3 of a running frame -> position restarts at (0,0), no frame_done, next full frame reports only its own corners.
6. reset asserted with 3 events buffered -> out_valid=0, fifo_level=0, drop_count=0 on the next edge. Repeat scenario 1 with the macro undefined -> out_score=0.

Source files
------------

// File: rtl/harris_pkg.sv
// Shared defaults and the corner event record for the Harris corner logger.
// Build option: define CORNER_LOG_SCORE_EN to carry the Harris score with each event.
// No logic; types and constants only.
package harris_pkg;

    localparam int IMG_W_DEF   = 640;
    localparam int IMG_H_DEF   = 480;
    localparam int SCORE_W_DEF = 64;
    localparam int XW_DEF      = $clog2(IMG_W_DEF);
    localparam int YW_DEF      = $clog2(IMG_H_DEF);

    // Event record at default image geometry; the logger builds its own
    // copy sized to its actual parameters.
    typedef struct packed {
        logic [XW_DEF-1:0]             x;
        logic [YW_DEF-1:0]             y;
`ifdef CORNER_LOG_SCORE_EN
        logic signed [SCORE_W_DEF-1:0] score;
`endif
    } corner_evt_t;

endpackage

// File: rtl/corner_evt_fifo.sv
// First-word-fall-through synchronous FIFO holding corner events.
// Latency: a word pushed into an empty FIFO appears on rd_dat the next cycle.
// Backpressure: push while full is accepted only alongside a pop; rd_dat reads 0 when empty.
// Ports: clk, reset (async high), push/wr_dat, pop/rd_dat, full, empty, level.
module corner_evt_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wr_dat,
    input  logic                     pop,
    output logic [W-1:0]             rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being read out this cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/harris_corner_logger.sv
// Turns Harris corner decisions into a buffered (x, y, score) event stream with frame accounting.
// Latency: event visible on out_* one cycle after its result; frame_done one cycle after the last pixel.
// Backpressure: out_valid/out_ready drain; input never stalls, events lost to a full FIFO bump drop_count.
// Ports: clk, reset (async high); in_valid/sof/is_corner/score in; out_valid/out_ready/out_x/out_y/out_score
// stream; frame_done, corner_count, drop_count, fifo_level status. Build option: CORNER_LOG_SCORE_EN.
module harris_corner_logger
    import harris_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int XW      = $clog2(IMG_W),
    parameter int YW      = $clog2(IMG_H),
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic                        sof,
    input  logic                        is_corner,
    input  logic signed [SCORE_W-1:0]   score,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XW-1:0]               out_x,
    output logic [YW-1:0]               out_y,
    output logic signed [SCORE_W-1:0]   out_score,
    output logic                        frame_done,
    output logic [CNT_W-1:0]            corner_count,
    output logic [15:0]                 drop_count,
    output logic [$clog2(DEPTH):0]      fifo_level
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [XW-1:0]             x;
        logic [YW-1:0]             y;
`ifdef CORNER_LOG_SCORE_EN
        logic signed [SCORE_W-1:0] score;
`endif
    } evt_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CNT_W-1:0] run_cnt;

    logic            accept;
    logic [XW-1:0]   px;
    logic [YW-1:0]   py;
    logic            x_last;
    logic            y_last;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            drop;
    evt_t            wr_evt;
    evt_t            rd_evt;

    // sof always names the current result (0,0), whether idle or mid-frame.
    assign accept   = in_valid && (sof || (state == RUN));
    assign px       = sof ? '0 : x;
    assign py       = sof ? '0 : y;
    assign x_last   = (px == XW'(IMG_W - 1));
    assign y_last   = (py == YW'(IMG_H - 1));
    assign cnt_base = sof ? '0 : run_cnt;
    assign cnt_next = (is_corner && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;

    assign push = accept && is_corner;
    assign pop  = out_valid && out_ready;
    assign drop = push && full && !pop;

    always_comb begin
        wr_evt   = '0;
        wr_evt.x = px;
        wr_evt.y = py;
`ifdef CORNER_LOG_SCORE_EN
        wr_evt.score = score;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            run_cnt      <= '0;
            frame_done   <= 1'b0;
            corner_count <= '0;
            drop_count   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (accept) begin
                if (x_last && y_last) begin
                    state        <= IDLE;
                    x            <= '0;
                    y            <= '0;
                    run_cnt      <= '0;
                    frame_done   <= 1'b1;
                    corner_count <= cnt_next;
                end else begin
                    state   <= RUN;
                    run_cnt <= cnt_next;
                    if (x_last) begin
                        x <= '0;
                        y <= py + 1'b1;
                    end else begin
                        x <= px + 1'b1;
                        y <= py;
                    end
                end
            end
        end
    end

    corner_evt_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(evt_t))
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .wr_dat (wr_evt),
        .pop    (pop),
        .rd_dat (rd_evt),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

    assign out_valid = !empty;
    assign out_x     = rd_evt.x;
    assign out_y     = rd_evt.y;
`ifdef CORNER_LOG_SCORE_EN
    assign out_score = rd_evt.score;
`else
    assign out_score = '0;
    logic unused_score;
    assign unused_score = ^score;
`endif

endmodule

// File: tb/tb_harris_corner_logger.sv
module tb_harris_corner_logger;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               sof = 1'b0;
    logic               is_corner = 1'b0;
    logic signed [63:0] score = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [1:0]         out_x;
    logic [0:0]         out_y;
    logic signed [63:0] out_score;
    logic               frame_done;
    logic [31:0]        corner_count;
    logic [15:0]        drop_count;
    logic [2:0]         fifo_level;

    int total = 0;
    int bad   = 0;

    harris_corner_logger #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .in_valid     (in_valid),
        .sof          (sof),
        .is_corner    (is_corner),
        .score        (score),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_score    (out_score),
        .frame_done   (frame_done),
        .corner_count (corner_count),
        .drop_count   (drop_count),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position as a linear pixel index, buffer as a queue.
    typedef struct {
        int          x;
        int          y;
        logic [63:0] sc;
    } ev_t;

    ev_t         exp_q[$];
    int          occ = 0;
    int          idx = 0;
    bit          in_frame = 0;
    int          run = 0;
    int          m_drop = 0;
    bit          m_fd = 0;
    int          m_cc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            occ = 0; idx = 0; in_frame = 0; run = 0;
            m_drop = 0; m_fd = 0; m_cc = 0;
        end else begin
            bit pop_m;
            bit push_m;
            ev_t e;
            pop_m  = (occ > 0) && out_ready;
            push_m = 0;
            m_fd   = 0;
            if (in_valid && (sof || in_frame)) begin
                if (sof) begin
                    idx = 0;
                    run = 0;
                end
                if (is_corner) begin
                    run++;
                    push_m = 1;
                    e.x = idx % IMG_W;
                    e.y = idx / IMG_W;
`ifdef CORNER_LOG_SCORE_EN
                    e.sc = score;
`else
                    e.sc = '0;
`endif
                end
                if (idx == NPIX - 1) begin
                    m_fd = 1;
                    m_cc = run;
                    run = 0;
                    idx = 0;
                    in_frame = 0;
                end else begin
                    idx++;
                    in_frame = 1;
                end
            end
            if (push_m) begin
                if (occ < DEPTH || pop_m) begin
                    exp_q.push_back(e);
                    occ++;
                end else if (m_drop < 16'hFFFF) begin
                    m_drop++;
                end
            end
            if (pop_m) occ--;
        end
    end

    // Monitor: compares status every cycle and each popped event against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("fifo_level", fifo_level, exp_q.size());
            chk("drop_count", drop_count, m_drop);
            chk("frame_done", frame_done, m_fd);
            chk("corner_count", corner_count, m_cc);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                ev_t h;
                h = exp_q.pop_front();
                chk("evt_x", out_x, h.x);
                chk("evt_y", out_y, h.y);
                chk("evt_score", out_score, h.sc);
            end else if (!out_valid) begin
                chk("idle_x", out_x, 0);
                chk("idle_y", out_y, 0);
                chk("idle_score", out_score, 0);
            end
        end
    end

    task automatic drive(input bit v, input bit s, input bit c);
        in_valid  = v;
        sof       = s;
        is_corner = c;
        score     = {$urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_corner_count", corner_count, 0);
        chk("rst_drop_count", drop_count, 0);
        rst = 0;
        idle(1);

        // 1: corners at indices 1 and 6
        out_ready = 1;
        for (int i = 0; i < NPIX; i++) drive(1, i == 0, i == 1 || i == 6);
        idle(3);
        chk("s1_corner_count", corner_count, 2);

        // 2: in_valid without sof while idle is ignored
        for (int i = 0; i < 3; i++) drive(1, 0, 1);
        idle(2);
        chk("s2_level", fifo_level, 0);
        chk("s2_corner_count", corner_count, 2);

        // 3: blocked consumer, 6 corners in one frame
        out_ready = 0;
        for (int i = 0; i < NPIX; i++) drive(1, i == 0, i < 6);
        idle(1);
        chk("s3_level", fifo_level, 4);
        chk("s3_drop", drop_count, 2);
        chk("s3_corner_count", corner_count, 6);
        out_ready = 1;
        idle(6);
        chk("s3_drained", out_valid, 0);

        // 4: full FIFO, push and pop in the same cycle
        out_ready = 0;
        for (int i = 0; i < 4; i++) drive(1, i == 0, 1);
        chk("s4_full", fifo_level, 4);
        out_ready = 1;
        drive(1, 0, 1);
        chk("s4_level_hold", fifo_level, 4);
        chk("s4_no_drop", drop_count, 2);
        for (int i = 5; i < NPIX; i++) drive(1, 0, 0);
        idle(6);

        // 5: sof mid-frame restarts the frame
        drive(1, 1, 0); drive(1, 0, 1); drive(1, 0, 0);
        for (int i = 0; i < NPIX; i++) drive(1, i == 0, i == 0 || i == 5);
        idle(2);
        chk("s5_corner_count", corner_count, 2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom % 3) != 0;
            drive(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom % 2);
        end
        out_ready = 1;
        idle(8);

        // 6: reset with events buffered, then a clean frame
        out_ready = 0;
        for (int i = 0; i < 3; i++) drive(1, i == 0, 1);
        rst = 1;
        @(posedge clk);
        #1;
        chk("s6_out_valid", out_valid, 0);
        chk("s6_level", fifo_level, 0);
        chk("s6_drop", drop_count, 0);
        rst = 0;
        out_ready = 1;
        idle(1);
        for (int i = 0; i < NPIX; i++) drive(1, i == 0, i == 1 || i == 6);
        idle(4);
        chk("s6_corner_count", corner_count, 2);
        chk("end_empty", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
